// File: rtl/bus_wb_master.sv
`default_nettype none
// ============================================================================
// Module   : bus_wb_master
// Purpose  : Single-channel Wishbone classic master. Takes one arbitrated
//            request at a time, runs one bus cycle for it and returns a
//            single-cycle tagged response. A bus timeout keeps a hung slave
//            from stalling the requesting core forever.
// Ports    : clk, rst (async, active-low)
//            cmd_*  : request from arbiter (valid/core_id/we/sel/adr/dat)
//            rdy    : request accepted when cmd_valid & rdy at a clock edge
//            wb_*   : Wishbone classic master signals
//            rsp_*  : one-cycle response pulse with tag, data and error flag
// Revision : 1.0 - initial release
// ============================================================================
module bus_wb_master #(
    parameter int unsigned CORE_ID_W = 2,
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] TO_DATA   = 32'hFFFF_FFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    // request side
    input  logic                 cmd_valid,
    input  logic [CORE_ID_W-1:0] cmd_core_id,
    input  logic                 cmd_we,
    input  logic [3:0]           cmd_sel,
    input  logic [31:0]          cmd_adr,
    input  logic [31:0]          cmd_dat,
    output logic                 rdy,
    // Wishbone side
    output logic                 wb_cyc,
    output logic                 wb_stb,
    output logic                 wb_we,
    output logic [3:0]           wb_sel,
    output logic [31:0]          wb_adr,
    output logic [31:0]          wb_datw,
    input  logic                 wb_ack,
    input  logic                 wb_err,
    input  logic [31:0]          wb_datr,
    // response side
    output logic                 rsp_valid,
    output logic [CORE_ID_W-1:0] rsp_core_id,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err
);

    // Counter only needs to reach TIMEOUT; at least one bit so the
    // declaration stays legal when the timeout is disabled.
    localparam int unsigned c_CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned c_TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam int unsigned c_CNT_MAX_I = TIMEOUT;
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(c_TO_LAST_I);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(c_CNT_MAX_I);
    localparam logic               c_TO_EN   = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   cyc_q, cyc_d;
    logic                   we_q, we_d;
    logic [3:0]             sel_q, sel_d;
    logic [31:0]            adr_q, adr_d;
    logic [31:0]            datw_q, datw_d;
    logic [CORE_ID_W-1:0]   tag_q, tag_d;
    logic [c_CNT_W-1:0]     cnt_q, cnt_d;
    logic [CORE_ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [31:0]            rsp_data_q, rsp_data_d;
    logic                   rsp_err_q, rsp_err_d;

    logic                   w_rdy;
    logic                   w_accept;
    logic                   w_timeout;
    logic                   w_fail;

    // rdy is forced low during reset even though the state already reads IDLE.
    assign w_rdy     = rst && ((state_q == IDLE) || (state_q == RSP));
    assign w_accept  = cmd_valid && w_rdy;
    assign w_timeout = c_TO_EN && (cnt_q == c_TO_LAST);
    // Error beats ack; ack beats a timeout firing in the same cycle.
    assign w_fail    = wb_err || (!wb_ack && w_timeout);

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        sel_d      = sel_q;
        adr_d      = adr_q;
        datw_d     = datw_q;
        tag_d      = tag_q;
        cnt_d      = cnt_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        unique case (state_q)
            IDLE, RSP: begin
                if (w_accept) begin
                    state_d = BUS;
                    cyc_d   = 1'b1;
                    we_d    = cmd_we;
                    sel_d   = cmd_sel;
                    adr_d   = cmd_adr;
                    datw_d  = cmd_dat;
                    tag_d   = cmd_core_id;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            BUS: begin
                if (wb_err || wb_ack || w_timeout) begin
                    state_d   = RSP;
                    cyc_d     = 1'b0;
                    rsp_id_d  = tag_q;
                    rsp_err_d = w_fail;
                    if (we_q) begin
                        rsp_data_d = 32'h0;
                    end else if (w_fail) begin
                        rsp_data_d = TO_DATA;
                    end else begin
                        rsp_data_d = wb_datr;
                    end
                end else if (cnt_q != c_CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            adr_q      <= '0;
            datw_q     <= '0;
            tag_q      <= '0;
            cnt_q      <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            adr_q      <= adr_d;
            datw_q     <= datw_d;
            tag_q      <= tag_d;
            cnt_q      <= cnt_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rdy         = w_rdy;
    assign wb_cyc      = cyc_q;
    assign wb_stb      = cyc_q;
    assign wb_we       = cyc_q && we_q;
    assign wb_sel      = sel_q;
    assign wb_adr      = adr_q;
    assign wb_datw     = datw_q;
    assign rsp_valid   = (state_q == RSP);
    assign rsp_core_id = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_wb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_wb_master
// Purpose  : Directed self-checking bench for bus_wb_master (TIMEOUT = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_wb_master;

    localparam int unsigned c_IDW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cmd_valid = 1'b0;
    logic [c_IDW-1:0]  cmd_core_id = '0;
    logic              cmd_we = 1'b0;
    logic [3:0]        cmd_sel = 4'h0;
    logic [31:0]       cmd_adr = 32'h0;
    logic [31:0]       cmd_dat = 32'h0;
    logic              rdy;
    logic              wb_cyc, wb_stb, wb_we;
    logic [3:0]        wb_sel;
    logic [31:0]       wb_adr, wb_datw;
    logic              wb_ack = 1'b0;
    logic              wb_err = 1'b0;
    logic [31:0]       wb_datr = 32'h0;
    logic              rsp_valid;
    logic [c_IDW-1:0]  rsp_core_id;
    logic [31:0]       rsp_data;
    logic              rsp_err;

    int n_cmp = 0;
    int n_err = 0;

    bus_wb_master #(
        .CORE_ID_W (c_IDW),
        .TIMEOUT   (8),
        .TO_DATA   (32'hFFFF_FFFF)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_core_id (cmd_core_id),
        .cmd_we      (cmd_we),
        .cmd_sel     (cmd_sel),
        .cmd_adr     (cmd_adr),
        .cmd_dat     (cmd_dat),
        .rdy         (rdy),
        .wb_cyc      (wb_cyc),
        .wb_stb      (wb_stb),
        .wb_we       (wb_we),
        .wb_sel      (wb_sel),
        .wb_adr      (wb_adr),
        .wb_datw     (wb_datw),
        .wb_ack      (wb_ack),
        .wb_err      (wb_err),
        .wb_datr     (wb_datr),
        .rsp_valid   (rsp_valid),
        .rsp_core_id (rsp_core_id),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [1:0] id, input logic we, input logic [3:0] sel,
                       input logic [31:0] adr, input logic [31:0] dat);
        cmd_valid   = 1'b1;
        cmd_core_id = id;
        cmd_we      = we;
        cmd_sel     = sel;
        cmd_adr     = adr;
        cmd_dat     = dat;
    endtask

    int n;
    int saw_rsp;

    initial begin
        // ---------------- reset state ----------------
        #2;
        chk("rst_rdy",   {31'b0, rdy},       32'd0);
        chk("rst_cyc",   {31'b0, wb_cyc},    32'd0);
        chk("rst_stb",   {31'b0, wb_stb},    32'd0);
        chk("rst_rspv",  {31'b0, rsp_valid}, 32'd0);
        chk("rst_adr",   wb_adr,             32'd0);
        chk("rst_data",  rsp_data,           32'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("idle_rdy",  {31'b0, rdy},       32'd1);

        // ---------------- 1: read, ack 3 cycles after stb ----------------
        req(2'd2, 1'b0, 4'hF, 32'h0000_1000, 32'h0);
        tick();
        cmd_valid = 1'b0;
        chk("t1_cyc",    {31'b0, wb_cyc},    32'd1);
        chk("t1_stb",    {31'b0, wb_stb},    32'd1);
        chk("t1_adr",    wb_adr,             32'h0000_1000);
        chk("t1_rdy",    {31'b0, rdy},       32'd0);
        tick();
        tick();
        wb_ack  = 1'b1;
        wb_datr = 32'hCAFE_F00D;
        tick();
        wb_ack  = 1'b0;
        wb_datr = 32'h0;
        chk("t1_rspv",   {31'b0, rsp_valid}, 32'd1);
        chk("t1_id",     {30'b0, rsp_core_id}, 32'd2);
        chk("t1_data",   rsp_data,           32'hCAFE_F00D);
        chk("t1_err",    {31'b0, rsp_err},   32'd0);
        chk("t1_cyclo",  {31'b0, wb_cyc},    32'd0);
        tick();
        chk("t1_rspv1",  {31'b0, rsp_valid}, 32'd0);
        chk("t1_rdy1",   {31'b0, rdy},       32'd1);

        // ---------------- 2: write, immediate ack ----------------
        req(2'd1, 1'b1, 4'b0011, 32'h0000_0020, 32'h1234_5678);
        tick();
        cmd_valid = 1'b0;
        chk("t2_we",     {31'b0, wb_we},     32'd1);
        chk("t2_sel",    {28'b0, wb_sel},    32'h3);
        chk("t2_datw",   wb_datw,            32'h1234_5678);
        wb_ack  = 1'b1;
        wb_datr = 32'hDEAD_BEEF;
        tick();
        wb_ack  = 1'b0;
        chk("t2_rspv",   {31'b0, rsp_valid}, 32'd1);
        chk("t2_data",   rsp_data,           32'h0);
        chk("t2_err",    {31'b0, rsp_err},   32'd0);
        tick();

        // ---------------- 3: timeout on read, then normal request ----------------
        req(2'd1, 1'b0, 4'hF, 32'h0000_0040, 32'h0);
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (wb_cyc && n < 20) begin
            n++;
            tick();
        end
        chk("t3_cyclen", n,                  32'd8);
        chk("t3_rspv",   {31'b0, rsp_valid}, 32'd1);
        chk("t3_err",    {31'b0, rsp_err},   32'd1);
        chk("t3_data",   rsp_data,           32'hFFFF_FFFF);
        req(2'd3, 1'b0, 4'hF, 32'h0000_0044, 32'h0);
        tick();
        cmd_valid = 1'b0;
        chk("t3_cyc2",   {31'b0, wb_cyc},    32'd1);
        wb_ack  = 1'b1;
        wb_datr = 32'h0000_55AA;
        tick();
        wb_ack  = 1'b0;
        chk("t3_rspv2",  {31'b0, rsp_valid}, 32'd1);
        chk("t3_id2",    {30'b0, rsp_core_id}, 32'd3);
        chk("t3_data2",  rsp_data,           32'h0000_55AA);
        chk("t3_err2",   {31'b0, rsp_err},   32'd0);
        tick();

        // ---------------- 4a: ack and err together ----------------
        req(2'd0, 1'b0, 4'hF, 32'h0000_0080, 32'h0);
        tick();
        cmd_valid = 1'b0;
        wb_ack  = 1'b1;
        wb_err  = 1'b1;
        wb_datr = 32'h1111_1111;
        tick();
        wb_ack  = 1'b0;
        wb_err  = 1'b0;
        chk("t4a_rspv",  {31'b0, rsp_valid}, 32'd1);
        chk("t4a_err",   {31'b0, rsp_err},   32'd1);
        chk("t4a_data",  rsp_data,           32'hFFFF_FFFF);
        tick();

        // ---------------- 4b: ack on the timeout cycle ----------------
        req(2'd2, 1'b0, 4'hF, 32'h0000_0084, 32'h0);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("t4b_cyc8",  {31'b0, wb_cyc},    32'd1);
        wb_ack  = 1'b1;
        wb_datr = 32'hA5A5_0001;
        tick();
        wb_ack  = 1'b0;
        chk("t4b_rspv",  {31'b0, rsp_valid}, 32'd1);
        chk("t4b_err",   {31'b0, rsp_err},   32'd0);
        chk("t4b_data",  rsp_data,           32'hA5A5_0001);
        tick();

        // ---------------- 5: back-to-back with cmd_valid held ----------------
        req(2'd0, 1'b0, 4'hF, 32'h0000_0100, 32'h0);
        tick();
        chk("t5_cycA",   {31'b0, wb_cyc},    32'd1);
        chk("t5_rdyA",   {31'b0, rdy},       32'd0);
        cmd_core_id = 2'd1;
        cmd_adr     = 32'h0000_0104;
        wb_ack      = 1'b1;
        wb_datr     = 32'h0000_00A0;
        tick();
        chk("t5_rspA",   {31'b0, rsp_valid}, 32'd1);
        chk("t5_idA",    {30'b0, rsp_core_id}, 32'd0);
        chk("t5_gapA",   {31'b0, wb_cyc},    32'd0);
        tick();
        chk("t5_cycB",   {31'b0, wb_cyc},    32'd1);
        chk("t5_rdyB",   {31'b0, rdy},       32'd0);
        chk("t5_adrB",   wb_adr,             32'h0000_0104);
        cmd_core_id = 2'd3;
        cmd_adr     = 32'h0000_0108;
        tick();
        chk("t5_rspB",   {31'b0, rsp_valid}, 32'd1);
        chk("t5_idB",    {30'b0, rsp_core_id}, 32'd1);
        chk("t5_gapB",   {31'b0, wb_cyc},    32'd0);
        tick();
        chk("t5_cycC",   {31'b0, wb_cyc},    32'd1);
        chk("t5_rdyC",   {31'b0, rdy},       32'd0);
        cmd_valid = 1'b0;
        tick();
        chk("t5_rspC",   {31'b0, rsp_valid}, 32'd1);
        chk("t5_idC",    {30'b0, rsp_core_id}, 32'd3);
        tick();
        // ack still high while idle: must be ignored
        chk("t5_idlev",  {31'b0, rsp_valid}, 32'd0);
        chk("t5_idlec",  {31'b0, wb_cyc},    32'd0);
        wb_ack = 1'b0;
        tick();

        // ---------------- 6: reset during outstanding read ----------------
        req(2'd1, 1'b0, 4'hF, 32'h0000_0200, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("t6_cycpre", {31'b0, wb_cyc},    32'd1);
        rst = 1'b0;
        #1;
        chk("t6_cycasy", {31'b0, wb_cyc},    32'd0);
        chk("t6_stbasy", {31'b0, wb_stb},    32'd0);
        chk("t6_rdyrst", {31'b0, rdy},       32'd0);
        saw_rsp = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (rsp_valid) saw_rsp++;
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid) saw_rsp++;
        end
        chk("t6_norsp",  saw_rsp,            32'd0);
        chk("t6_rdy",    {31'b0, rdy},       32'd1);
        chk("t6_cyc",    {31'b0, wb_cyc},    32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time guard so the run can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, observed %0d compared", n_cmp);
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
